bus_fabric: RTL and testbench

Parametrised successor to the fixed 11-slot CPU bus arbiter. Decodes the CPU instruction and data addresses onto NSLAVE memory-mapped modules and muxes read data back. Adds what the fixed arbiter lacks: per-slave ready handshake, serialisation of I/D collisions on the same single-ported slave, a stall watchdog, and sticky bus-error capture. Sits between the CPU and all mod_* slaves.

---
 rtl/bus_pkg.sv | 30 +++
 rtl/bus_decode.sv | 23 ++
 rtl/bus_fabric.sv | 163 ++++++++++++++++
 tb/tb_bus_fabric.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared constants and helpers for the CPU bus fabric and its address decoders.
package bus_pkg;

   localparam int DW          = 32;
   localparam int NSLAVE_DEF  = 11;
   localparam int SEL_HI_DEF  = 31;
   localparam int SEL_LO_DEF  = 24;
   localparam int TIMEOUT_DEF = 255;

   localparam int MOD_ROM      = 0;
   localparam int MOD_RAM      = 1;
   localparam int MOD_UART     = 2;
   localparam int MOD_SWITCHES = 3;
   localparam int MOD_LEDS     = 4;
   localparam int MOD_PLPID    = 8;
   localparam int MOD_TIMER    = 9;
   localparam int MOD_SSEG     = 10;

   // Data returned for unmapped accesses and watchdog-forced completions.
   localparam logic [DW-1:0] ERR_DATA = '0;

   function automatic logic [DW-1:0] sel_mask(input int hi, input int lo);
      logic [DW-1:0] m;
      for (int i = 0; i < DW; i++) begin
         m[i] = (i >= lo) && (i <= hi);
      end
      return m;
   endfunction

endpackage

// File: rtl/bus_decode.sv
// Address decoder: extracts the slot index, flags unmapped slots, and zeroes
// the select field to form the slave-relative address.
module bus_decode
   import bus_pkg::*;
#(
   parameter int NSLAVE = NSLAVE_DEF,
   parameter int SEL_HI = SEL_HI_DEF,
   parameter int SEL_LO = SEL_LO_DEF,
   parameter int SW     = SEL_HI - SEL_LO + 1
) (
   input  logic [DW-1:0] i_addr,
   output logic [SW-1:0] o_slot,
   output logic          o_mapped,
   output logic [DW-1:0] o_eff_addr
);

   localparam logic [DW-1:0] SEL_MASK = sel_mask(SEL_HI, SEL_LO);

   assign o_slot     = i_addr[SEL_HI:SEL_LO];
   assign o_mapped   = int'(o_slot) < NSLAVE;
   assign o_eff_addr = i_addr & ~SEL_MASK;

endmodule

// File: rtl/bus_fabric.sv
// CPU bus fabric: decodes instruction and data addresses onto NSLAVE slots with
// ready handshake, I/D collision serialisation, stall watchdog and sticky errors.
module bus_fabric
   import bus_pkg::*;
#(
   parameter int NSLAVE  = NSLAVE_DEF,
   parameter int SEL_HI  = SEL_HI_DEF,
   parameter int SEL_LO  = SEL_LO_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DW-1:0]        cpu_iaddr,
   input  logic [DW-1:0]        cpu_daddr,
   input  logic                 cpu_dreq,
   input  logic                 cpu_drw,
   input  logic [DW-1:0]        cpu_bus_data,
   output logic [DW-1:0]        bus_cpu_inst,
   output logic [DW-1:0]        bus_cpu_data,
   output logic                 cpu_stall,
   output logic                 bus_err,
   output logic [DW-1:0]        err_addr,
   input  logic                 err_clr,
   output logic [NSLAVE-1:0]    slv_ie,
   output logic [NSLAVE-1:0]    slv_de,
   output logic [DW-1:0]        slv_iaddr,
   output logic [DW-1:0]        slv_daddr,
   output logic                 slv_drw,
   output logic [DW-1:0]        slv_wdata,
   input  logic [DW*NSLAVE-1:0] slv_idata,
   input  logic [DW*NSLAVE-1:0] slv_ddata,
   input  logic [NSLAVE-1:0]    slv_ready
);

   localparam int SW    = SEL_HI - SEL_LO + 1;
   localparam int SCW_T = $clog2(TIMEOUT + 1);
   localparam int SCW   = (SCW_T < 8) ? 8 : SCW_T;

   logic [SW-1:0]  w_imod, w_dmod;
   logic           w_imapped, w_dmapped;
   logic           r_i_done, r_d_done;
   logic [DW-1:0]  r_i_hold, r_d_hold;
   logic [SCW-1:0] r_scnt;
   logic           r_bus_err;
   logic [DW-1:0]  r_err_addr;

   logic           w_conf, w_i_act, w_d_act, w_timeout;
   logic           w_i_rdy, w_d_rdy, w_i_cmp, w_d_cmp;
   logic [DW-1:0]  w_i_live, w_d_live, w_i_rd, w_d_rd;
   logic           w_stall, w_err_new, w_err_use_d;

   bus_decode #(.NSLAVE(NSLAVE), .SEL_HI(SEL_HI), .SEL_LO(SEL_LO)) u_idec (
      .i_addr     (cpu_iaddr),
      .o_slot     (w_imod),
      .o_mapped   (w_imapped),
      .o_eff_addr (slv_iaddr)
   );

   bus_decode #(.NSLAVE(NSLAVE), .SEL_HI(SEL_HI), .SEL_LO(SEL_LO)) u_ddec (
      .i_addr     (cpu_daddr),
      .o_slot     (w_dmod),
      .o_mapped   (w_dmapped),
      .o_eff_addr (slv_daddr)
   );

   assign slv_drw   = cpu_drw;
   assign slv_wdata = cpu_bus_data;

   // Data wins a collision on a single-ported slave; I waits until D is done.
   assign w_conf    = cpu_dreq && w_dmapped && (w_imod == w_dmod);
   assign w_i_act   = !r_i_done && !(w_conf && !r_d_done);
   assign w_d_act   = cpu_dreq && !r_d_done;
   assign w_timeout = (r_scnt == SCW'(TIMEOUT));

   // NOTE: every signal assigned in always_comb gets a default first so no path
   // leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      w_i_live = '0;
      w_d_live = '0;
      w_i_rdy  = !w_imapped;
      w_d_rdy  = !w_dmapped;
      for (int k = 0; k < NSLAVE; k++) begin
         if (w_imapped && int'(w_imod) == k) begin
            w_i_live = slv_idata[k*DW +: DW];
            w_i_rdy  = slv_ready[k];
         end
         if (w_dmapped && int'(w_dmod) == k) begin
            w_d_live = slv_ddata[k*DW +: DW];
            w_d_rdy  = slv_ready[k];
         end
      end
   end

   assign w_i_cmp = (w_i_act && w_i_rdy) || (w_timeout && !r_i_done);
   assign w_d_cmp = (w_d_act && w_d_rdy) || (w_timeout && w_d_act);

   // A watchdog-forced completion returns ERR_DATA, not whatever the slave shows.
   assign w_i_rd = (w_timeout && !(w_i_act && w_i_rdy)) ? ERR_DATA : w_i_live;
   assign w_d_rd = (w_timeout && !(w_d_act && w_d_rdy)) ? ERR_DATA : w_d_live;

   assign bus_cpu_inst = r_i_done ? r_i_hold : w_i_rd;
   assign bus_cpu_data = r_d_done ? r_d_hold : w_d_rd;

   assign w_stall   = !((r_i_done || w_i_cmp) &&
                        (r_d_done || !cpu_dreq || w_d_cmp));
   assign cpu_stall = !rst && w_stall;

   always_comb begin
      slv_ie = '0;
      slv_de = '0;
      for (int k = 0; k < NSLAVE; k++) begin
         slv_ie[k] = !rst && w_i_act && w_imapped && (int'(w_imod) == k);
         slv_de[k] = !rst && w_d_act && w_dmapped && (int'(w_dmod) == k);
      end
   end

   assign w_err_use_d = w_d_act && (!w_dmapped || w_timeout);
   assign w_err_new   = w_err_use_d || (w_i_act && !w_imapped) || w_timeout;

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_i_done   <= 1'b0;
         r_d_done   <= 1'b0;
         r_i_hold   <= '0;
         r_d_hold   <= '0;
         r_scnt     <= '0;
         r_bus_err  <= 1'b0;
         r_err_addr <= '0;
      end else begin
         if (!w_stall) begin
            r_i_done <= 1'b0;
            r_d_done <= 1'b0;
            r_scnt   <= '0;
         end else begin
            if (w_i_cmp) begin
               r_i_done <= 1'b1;
               r_i_hold <= w_i_rd;
            end
            if (w_d_cmp) begin
               r_d_done <= 1'b1;
               r_d_hold <= w_d_rd;
            end
            r_scnt <= r_scnt + SCW'(1);
         end

         // A new error outranks a simultaneous clear and reloads the address.
         if (w_err_new) begin
            r_bus_err <= 1'b1;
            if (!r_bus_err || err_clr) begin
               r_err_addr <= w_err_use_d ? cpu_daddr : cpu_iaddr;
            end
         end else if (err_clr) begin
            r_bus_err <= 1'b0;
         end
      end
   end

   assign bus_err  = r_bus_err;
   assign err_addr = r_err_addr;

endmodule

// File: tb/tb_bus_fabric.sv
// Directed self-checking bench for bus_fabric with static per-slot slave data.
module tb_bus_fabric;
   import bus_pkg::*;

   localparam int NS = 11;

   logic           clk = 1'b0;
   logic           rst;
   logic [31:0]    cpu_iaddr, cpu_daddr, cpu_bus_data;
   logic           cpu_dreq, cpu_drw, err_clr;
   logic [31:0]    bus_cpu_inst, bus_cpu_data, err_addr;
   logic           cpu_stall, bus_err;
   logic [NS-1:0]  slv_ie, slv_de, slv_ready;
   logic [31:0]    slv_iaddr, slv_daddr, slv_wdata;
   logic           slv_drw;
   logic [32*NS-1:0] slv_idata, slv_ddata;

   int total = 0;
   int bad   = 0;

   bus_fabric #(.NSLAVE(NS), .SEL_HI(31), .SEL_LO(24), .TIMEOUT(255)) dut (
      .clk          (clk),
      .rst          (rst),
      .cpu_iaddr    (cpu_iaddr),
      .cpu_daddr    (cpu_daddr),
      .cpu_dreq     (cpu_dreq),
      .cpu_drw      (cpu_drw),
      .cpu_bus_data (cpu_bus_data),
      .bus_cpu_inst (bus_cpu_inst),
      .bus_cpu_data (bus_cpu_data),
      .cpu_stall    (cpu_stall),
      .bus_err      (bus_err),
      .err_addr     (err_addr),
      .err_clr      (err_clr),
      .slv_ie       (slv_ie),
      .slv_de       (slv_de),
      .slv_iaddr    (slv_iaddr),
      .slv_daddr    (slv_daddr),
      .slv_drw      (slv_drw),
      .slv_wdata    (slv_wdata),
      .slv_idata    (slv_idata),
      .slv_ddata    (slv_ddata),
      .slv_ready    (slv_ready)
   );

   always #5 clk = ~clk;

   task automatic next_cycle;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1; err_clr = 1'b0;
      cpu_iaddr = 32'h0000_0010; cpu_daddr = 32'h0100_0000;
      cpu_dreq = 1'b1; cpu_drw = 1'b0; cpu_bus_data = '0;
      slv_ready = '1;
      @(negedge clk);
      total++; if (slv_ie !== '0 || slv_de !== '0) begin bad++; $display("FAIL rst_en: ie=%h de=%h want 0", slv_ie, slv_de); end
      total++; if (cpu_stall !== 1'b0) begin bad++; $display("FAIL rst_stall: got %b want 0", cpu_stall); end
      next_cycle();
      total++; if (bus_err !== 1'b0 || err_addr !== 32'h0) begin bad++; $display("FAIL rst_err: err=%b addr=%h want 0/0", bus_err, err_addr); end
      rst = 1'b0; cpu_dreq = 1'b0;
   endtask

   task automatic test_basic;
      cpu_iaddr = 32'h0000_0010; cpu_daddr = 32'h0100_0020; cpu_dreq = 1'b1; cpu_drw = 1'b0;
      @(negedge clk);
      total++; if (cpu_stall !== 1'b0) begin bad++; $display("FAIL basic_stall: got %b want 0", cpu_stall); end
      total++; if (bus_cpu_inst !== 32'hA000_0000) begin bad++; $display("FAIL basic_inst: got %h want a0000000", bus_cpu_inst); end
      total++; if (bus_cpu_data !== 32'hD000_0001) begin bad++; $display("FAIL basic_data: got %h want d0000001", bus_cpu_data); end
      total++; if (slv_daddr !== 32'h0000_0020 || slv_iaddr !== 32'h0000_0010) begin bad++; $display("FAIL basic_addr: d=%h i=%h want 20/10", slv_daddr, slv_iaddr); end
      total++; if (slv_ie !== 11'h001 || slv_de !== 11'h002) begin bad++; $display("FAIL basic_en: ie=%h de=%h want 001/002", slv_ie, slv_de); end
      next_cycle();
   endtask

   task automatic test_conflict;
      int writes = 0;
      cpu_iaddr = 32'h0100_0004; cpu_daddr = 32'h0100_0008; cpu_dreq = 1'b1; cpu_drw = 1'b1;
      cpu_bus_data = 32'h1234_5678;
      @(negedge clk);
      if (slv_de[MOD_RAM] && slv_drw) writes++;
      total++; if (cpu_stall !== 1'b1) begin bad++; $display("FAIL conf_c0_stall: got %b want 1", cpu_stall); end
      total++; if (slv_de !== 11'h002 || slv_ie !== 11'h000) begin bad++; $display("FAIL conf_c0_en: ie=%h de=%h want 000/002", slv_ie, slv_de); end
      total++; if (slv_wdata !== 32'h1234_5678) begin bad++; $display("FAIL conf_wdata: got %h want 12345678", slv_wdata); end
      next_cycle();
      @(negedge clk);
      if (slv_de[MOD_RAM] && slv_drw) writes++;
      total++; if (cpu_stall !== 1'b0) begin bad++; $display("FAIL conf_c1_stall: got %b want 0", cpu_stall); end
      total++; if (slv_ie !== 11'h002 || slv_de !== 11'h000) begin bad++; $display("FAIL conf_c1_en: ie=%h de=%h want 002/000", slv_ie, slv_de); end
      total++; if (bus_cpu_inst !== 32'hA000_0001) begin bad++; $display("FAIL conf_inst: got %h want a0000001", bus_cpu_inst); end
      total++; if (writes != 1) begin bad++; $display("FAIL conf_writes: got %0d want 1", writes); end
      next_cycle();
      cpu_dreq = 1'b0; cpu_drw = 1'b0;
   endtask

   task automatic test_wait;
      int stalls = 0;
      cpu_iaddr = 32'h0000_0040; cpu_daddr = 32'h0100_0010; cpu_dreq = 1'b1; cpu_drw = 1'b0;
      slv_ready = 11'h7FD;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         if (cpu_stall) stalls++;
         if (c > 0) begin
            total++; if (slv_ie !== '0 || slv_de !== 11'h002) begin bad++; $display("FAIL wait_en_c%0d: ie=%h de=%h want 000/002", c, slv_ie, slv_de); end
            total++; if (bus_cpu_inst !== 32'hA000_0000) begin bad++; $display("FAIL wait_hold_c%0d: got %h want a0000000", c, bus_cpu_inst); end
         end
         next_cycle();
      end
      slv_ready = '1;
      @(negedge clk);
      total++; if (stalls != 3) begin bad++; $display("FAIL wait_stalls: got %0d want 3", stalls); end
      total++; if (cpu_stall !== 1'b0) begin bad++; $display("FAIL wait_c3_stall: got %b want 0", cpu_stall); end
      total++; if (bus_cpu_data !== 32'hD000_0001) begin bad++; $display("FAIL wait_data: got %h want d0000001", bus_cpu_data); end
      next_cycle();
      cpu_dreq = 1'b0;
   endtask

   task automatic test_boundary;
      cpu_iaddr = 32'h0000_0010; cpu_daddr = 32'h0A00_0004; cpu_dreq = 1'b1;
      @(negedge clk);
      total++; if (bus_cpu_data !== 32'hD000_000A || slv_de !== 11'h400) begin bad++; $display("FAIL slot10: data=%h de=%h want d000000a/400", bus_cpu_data, slv_de); end
      next_cycle();
      total++; if (bus_err !== 1'b0) begin bad++; $display("FAIL slot10_err: got %b want 0", bus_err); end
      cpu_daddr = 32'h0F00_0000;
      @(negedge clk);
      total++; if (cpu_stall !== 1'b0 || bus_cpu_data !== 32'h0 || slv_de !== '0) begin bad++; $display("FAIL unmap: stall=%b data=%h de=%h want 0/0/0", cpu_stall, bus_cpu_data, slv_de); end
      next_cycle();
      total++; if (bus_err !== 1'b1 || err_addr !== 32'h0F00_0000) begin bad++; $display("FAIL unmap_err: err=%b addr=%h want 1/0f000000", bus_err, err_addr); end
      cpu_dreq = 1'b0; err_clr = 1'b1;
      next_cycle();
      err_clr = 1'b0;
      total++; if (bus_err !== 1'b0 || err_addr !== 32'h0F00_0000) begin bad++; $display("FAIL clr: err=%b addr=%h want 0/0f000000", bus_err, err_addr); end
   endtask

   task automatic test_timeout;
      int stalls = 0;
      cpu_iaddr = 32'h0000_0010; cpu_daddr = 32'h0200_0100; cpu_dreq = 1'b1; cpu_drw = 1'b0;
      slv_ready = 11'h7FB;
      for (int c = 0; c < 300; c++) begin
         @(negedge clk);
         if (!cpu_stall) break;
         stalls++;
         next_cycle();
      end
      total++; if (stalls != 255) begin bad++; $display("FAIL to_stalls: got %0d want 255", stalls); end
      total++; if (cpu_stall !== 1'b0 || bus_cpu_data !== 32'h0) begin bad++; $display("FAIL to_release: stall=%b data=%h want 0/0", cpu_stall, bus_cpu_data); end
      next_cycle();
      slv_ready = '1;
      total++; if (bus_err !== 1'b1 || err_addr !== 32'h0200_0100) begin bad++; $display("FAIL to_err: err=%b addr=%h want 1/02000100", bus_err, err_addr); end
      cpu_daddr = 32'h0F00_0004;
      next_cycle();
      total++; if (bus_err !== 1'b1 || err_addr !== 32'h0200_0100) begin bad++; $display("FAIL second_err: err=%b addr=%h want 1/02000100", bus_err, err_addr); end
      cpu_dreq = 1'b0; err_clr = 1'b1;
      next_cycle();
      total++; if (bus_err !== 1'b0) begin bad++; $display("FAIL to_clr: got %b want 0", bus_err); end
      cpu_iaddr = 32'h2000_0000;
      @(negedge clk);
      total++; if (bus_cpu_inst !== 32'h0 || cpu_stall !== 1'b0 || slv_ie !== '0) begin bad++; $display("FAIL iunmap: inst=%h stall=%b ie=%h want 0/0/0", bus_cpu_inst, cpu_stall, slv_ie); end
      next_cycle();
      err_clr = 1'b0;
      total++; if (bus_err !== 1'b1 || err_addr !== 32'h2000_0000) begin bad++; $display("FAIL clr_vs_err: err=%b addr=%h want 1/20000000", bus_err, err_addr); end
      cpu_iaddr = 32'h0000_0010;
   endtask

   task automatic test_reset_mid;
      cpu_iaddr = 32'h0000_0010; cpu_daddr = 32'h0100_0010; cpu_dreq = 1'b1; cpu_drw = 1'b0;
      slv_ready = 11'h7FD;
      @(negedge clk);
      total++; if (cpu_stall !== 1'b1) begin bad++; $display("FAIL rmid_stall: got %b want 1", cpu_stall); end
      next_cycle();
      rst = 1'b1;
      @(negedge clk);
      total++; if (slv_ie !== '0 || slv_de !== '0 || cpu_stall !== 1'b0) begin bad++; $display("FAIL rmid_rst: ie=%h de=%h stall=%b want 0/0/0", slv_ie, slv_de, cpu_stall); end
      next_cycle();
      rst = 1'b0; slv_ready = '1; cpu_dreq = 1'b0; cpu_iaddr = 32'h0000_0014;
      @(negedge clk);
      total++; if (cpu_stall !== 1'b0 || slv_ie !== 11'h001 || bus_cpu_inst !== 32'hA000_0000) begin bad++; $display("FAIL rmid_fetch: stall=%b ie=%h inst=%h want 0/001/a0000000", cpu_stall, slv_ie, bus_cpu_inst); end
      total++; if (bus_err !== 1'b0 || err_addr !== 32'h0) begin bad++; $display("FAIL rmid_err: err=%b addr=%h want 0/0", bus_err, err_addr); end
      next_cycle();
   endtask

   initial begin
      for (int k = 0; k < NS; k++) begin
         slv_idata[k*32 +: 32] = 32'hA000_0000 | 32'(k);
         slv_ddata[k*32 +: 32] = 32'hD000_0000 | 32'(k);
      end
      test_reset();
      test_basic();
      test_conflict();
      test_wait();
      test_boundary();
      test_timeout();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
